// File: rtl/fptosi_iter.sv
// fptosi_iter: iterative float32 -> signed int32 converter (truncate toward zero).
//
// The integer magnitude is built by shifting the 24-bit significand one bit
// per cycle toward its final position. The float sign then selects a
// two's-complement negation. NaN converts to 0. Inf and out-of-range values
// saturate. Zero, denormals and |x| < 1 convert to 0. One token is in flight
// at a time.
//
// Handshake: a token moves on a channel at a rising edge where valid and
// ready are both high. The producer holds its data and valid steady until
// that edge. outs and outs_valid stay stable from when outs_valid rises
// until the delivery edge. ins_ready is high only in IDLE, and never while
// rst is high.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   ins        float32 operand {sign, exponent[7:0], mantissa[22:0]}
//   ins_valid  operand valid
//   ins_ready  converter can accept an operand
//   outs       signed integer result (holds the last result in all states)
//   outs_valid result valid
//   outs_ready consumer accepts result
module fptosi_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    NEG   = 2'd2,
    OUT   = 2'd3
  } state_t;

  // state is left visible by name so checkers can bind to it
  state_t state;
  state_t state_n;

  logic                  sign_q;
  logic                  left_q;
  logic [4:0]            cnt;
  logic [DATA_WIDTH-1:0] mag;
  logic [DATA_WIDTH-1:0] result;

  // Operand decode, used only when a token is accepted in IDLE
  logic [7:0]  exp_f;
  logic [22:0] man_f;
  logic        is_nan;
  logic        is_sat;
  logic        is_small;
  logic        go_left;
  logic [4:0]  cnt_init;

  always_comb begin
    exp_f    = ins[30:23];
    man_f    = ins[22:0];
    is_nan   = (exp_f == 8'hFF) && (man_f != 23'd0);
    // Biased exponent 158 is E = 31; this range also holds Inf (255) and
    // exact -2^31, which saturates to the same 0x80000000
    is_sat   = (exp_f >= 8'd158) && !is_nan;
    // Biased exponent below 127 is E < 0; also covers zero and denormals
    is_small = (exp_f < 8'd127);
    // The significand's lsb sits at 2^(E-23), so E = 23 needs no shift
    go_left  = (exp_f > 8'd150);
    cnt_init = go_left ? 5'(exp_f - 8'd150) : 5'(8'd150 - exp_f);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (ins_valid) begin
          if (is_nan || is_sat || is_small) state_n = OUT;
          else if (cnt_init == 5'd0)        state_n = NEG;
          else                              state_n = SHIFT;
        end
      end
      SHIFT:   if (cnt == 5'd1) state_n = NEG;
      NEG:     state_n = OUT;
      OUT:     if (outs_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ins_ready  = (state == IDLE) && !rst;
    outs_valid = (state == OUT);
    outs       = result;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      cnt    <= '0;
      mag    <= '0;
      sign_q <= 1'b0;
      left_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ins_valid) begin
            sign_q <= ins[DATA_WIDTH-1];
            if (is_nan || is_small) begin
              result <= '0;
            end else if (is_sat) begin
              result <= ins[DATA_WIDTH-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else begin
              mag    <= {8'b0, 1'b1, man_f};
              cnt    <= cnt_init;
              left_q <= go_left;
            end
          end
        end
        SHIFT: begin
          // Bits that fall off the right are dropped, which truncates toward zero
          mag <= left_q ? (mag << 1) : (mag >> 1);
          cnt <= cnt - 5'd1;
        end
        NEG: begin
          // mag < 2^31 here, so negation cannot overflow
          result <= sign_q ? (~mag + 32'd1) : mag;
        end
        default: ;
      endcase
    end
  end

endmodule
